up_sequencer: RTL and testbench
===============================

Name: up_sequencer

Overview:
- Control unit for the 4-bit accumulator microprocessor. It owns the fetch/execute phase flip-flop, the 12-bit program counter, the instruction/operand fetch register and the C/Z flag register.
- It decodes each opcode into per-cycle enables for the ALU, accumulator, data-bus source, RAM and output latch.
- It sits between program ROM and datapath, replacing ad-hoc phase/PC logic inside uP.

Parameters:
- PC_W, 12, program counter and ROM/RAM address width
- PC_RESET, 12'h000, PC value after reset

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- stall  input  1  1 = freeze all state; all enables forced 0
- program_byte  input  8  ROM data at address PC
- alu_c  input  1  ALU carry/borrow result of current operation
- alu_z  input  1  ALU zero result of current operation
- PC  output  PC_W  program counter (ROM address)
- phase  output  1  0 = FETCH, 1 = EXECUTE
- instr  output  4  latched opcode (program_byte[7:4])
- oprnd  output  4  latched operand (program_byte[3:0])
- address_RAM  output  12  {oprnd, program_byte}, valid in EXECUTE
- c_flag  output  1  registered carry flag
- z_flag  output  1  registered zero flag
- alu_op  output  2  00 pass bus, 01 A-B, 10 A+B, 11 NAND
- bus_sel  output  2  00 accu, 01 oprnd, 10 RAM, 11 pushbuttons
- acc_we  output  1  accumulator load
- flags_we  output  1  informational copy of internal flag-load enable
- ram_re  output  1  RAM read/drive enable
- ram_we  output  1  RAM write enable
- out_we  output  1  output latch (FF_out) load

Behaviour:
- Reset (reset=0, async): PC=PC_RESET, phase=0, instr=oprnd=0, c_flag=z_flag=0. All enables are 0 while in reset and in FETCH.
- FETCH (phase=0), rising edge with stall=0:
  - instr/oprnd <= program_byte
  - PC <= PC+1
  - phase <= 1
- EXECUTE (phase=1): enables are a combinational decode of instr, c_flag, z_flag. Rising edge with stall=0:
  - phase <= 0
  - if flags_we: c_flag <= alu_c, z_flag <= alu_z
  - PC update per opcode, below
- One instruction = exactly 2 clocks. No extra cycle for 2-byte instructions: the second byte is read in EXECUTE at PC.
- Opcode decode (enables in EXECUTE only):
  - 0 JC: taken if c_flag. 2-byte.
  - 1 JNC: taken if !c_flag. 2-byte.
  - 8 JZ: taken if z_flag. 2-byte.
  - 9 JNZ: taken if !z_flag. 2-byte.
  - C JMP: always taken. 2-byte.
  - 2 CMPI: bus=01, alu=01, flags_we. Accumulator not written.
  - 3 CMPM: bus=10, ram_re, alu=01, flags_we. 2-byte.
  - 4 LIT: bus=01, alu=00, acc_we. Flags unchanged.
  - 5 IN: bus=11, alu=00, acc_we. Flags unchanged.
  - 6 LD: bus=10, ram_re, alu=00, acc_we. 2-byte.
  - 7 ST: bus=00, ram_we. 2-byte.
  - A ADDI: bus=01, alu=10, acc_we, flags_we.
  - B ADDM: bus=10, ram_re, alu=10, acc_we, flags_we. 2-byte.
  - D OUT: bus=00, out_we.
  - E NANDI: bus=01, alu=11, acc_we, flags_we.
  - F NANDM: bus=10, ram_re, alu=11, acc_we, flags_we. 2-byte.
- PC in EXECUTE:
  - taken jump: PC <= {oprnd, program_byte}
  - any other 2-byte opcode, incl. non-taken jump: PC <= PC+1
  - 1-byte opcode: PC unchanged
- Jump conditions use flags registered before this EXECUTE edge. Jumps never write flags.
- PC arithmetic is modulo 2^PC_W: PC=FFF increments to 000, no flag.
- Idle values: bus_sel=00, alu_op=00 in FETCH and when stalled.
- stall=1: phase, PC, instr, oprnd and flags hold. All *_we/ram_re are 0. Decode resumes unchanged when stall drops. A stall in EXECUTE does not lose the pending instruction.
- Reset mid-instruction: immediate return to reset state, with no partial write. Enables drop asynchronously with reset.

Test Plan:
- Reset, ROM[0]=8'h44 (LIT 4) -> after edge 1: phase=1, instr=4, oprnd=4, PC=001, acc_we=1, bus_sel=01, alu_op=00. After edge 2: phase=0, PC=001, flags unchanged.
- ROM[1]=8'hA7 (ADDI 7), drive alu_c=1, alu_z=0 in EXECUTE -> acc_we=1, flags_we=1, alu_op=10. After edge: c_flag=1, z_flag=0, PC=002.
- CMPI (8'h2B) with alu_c=0, alu_z=1 -> acc_we=0, flags_we=1. After edge: c_flag=0, z_flag=1.
- JMP: ROM[9]=8'hCA, ROM[00A]=8'h01 -> PC=00A during EXECUTE, address_RAM=A01. After edge: PC=A01.
- JZ with z_flag=0: ROM[4]=8'h83, ROM[5]=8'h21 -> PC=006 after EXECUTE. Repeat with z_flag=1 -> PC=321.
- stall=1 held 3 clocks during EXECUTE of ST (8'h7x) -> ram_we=0 and PC, phase frozen. Release stall -> ram_we=1 for exactly one cycle. Assert reset=0 mid-EXECUTE -> PC=000, phase=0, all enables 0 immediately.

Source files
------------

// File: rtl/up_sequencer_if.sv
// Sequencer <-> ROM/datapath bundle: fetch byte, ALU status in, PC/decode/enables out.
// Latency: n/a (signal bundle only).
// Backpressure: stall freezes the sequencer; master = sequencer, slave = ROM/datapath side.
// Ports: stall, program_byte, alu_c, alu_z (to sequencer); PC, phase, instr, oprnd,
//        address_RAM, c_flag, z_flag, alu_op, bus_sel, acc_we, flags_we, ram_re,
//        ram_we, out_we (from sequencer).
interface up_sequencer_if #(
   parameter int PC_W = 12
);
   logic            stall;
   logic [7:0]      program_byte;
   logic            alu_c;
   logic            alu_z;
   logic [PC_W-1:0] PC;
   logic            phase;
   logic [3:0]      instr;
   logic [3:0]      oprnd;
   logic [11:0]     address_RAM;
   logic            c_flag;
   logic            z_flag;
   logic [1:0]      alu_op;
   logic [1:0]      bus_sel;
   logic            acc_we;
   logic            flags_we;
   logic            ram_re;
   logic            ram_we;
   logic            out_we;

   modport master (
      input  stall, program_byte, alu_c, alu_z,
      output PC, phase, instr, oprnd, address_RAM, c_flag, z_flag,
             alu_op, bus_sel, acc_we, flags_we, ram_re, ram_we, out_we
   );

   modport slave (
      output stall, program_byte, alu_c, alu_z,
      input  PC, phase, instr, oprnd, address_RAM, c_flag, z_flag,
             alu_op, bus_sel, acc_we, flags_we, ram_re, ram_we, out_we
   );
endinterface

// File: rtl/up_sequencer.sv
// Control unit of the 4-bit accumulator CPU: fetch/execute phase, PC, opcode latch, C/Z flags, decode.
// Latency: every instruction takes exactly 2 clocks (FETCH then EXECUTE); enables are combinational in EXECUTE.
// Backpressure: stall=1 holds all state and forces every enable to 0; the pending instruction resumes intact.
// Ports: clock, reset (async active-low), bus (up_sequencer_if.master) carrying ROM byte,
//        ALU status, PC/phase/opcode/flags and the datapath enables.
module up_sequencer #(
   parameter int              PC_W     = 12,
   parameter logic [PC_W-1:0] PC_RESET = '0
) (
   input  logic          clock,
   input  logic          reset,
   up_sequencer_if.master bus
);

   typedef enum logic {
      FETCH   = 1'b0,
      EXECUTE = 1'b1
   } phase_t;

   phase_t          state;
   logic [PC_W-1:0] pc_q;
   logic [3:0]      instr_q;
   logic [3:0]      oprnd_q;
   logic            c_q;
   logic            z_q;

   // Raw decode of the latched opcode; masked by 'active' before leaving the block.
   logic       active;
   logic       two_byte;
   logic       taken;
   logic [1:0] alu_raw;
   logic [1:0] sel_raw;
   logic       acc_raw;
   logic       flg_raw;
   logic       rre_raw;
   logic       rwe_raw;
   logic       owe_raw;

   // reset is part of the gate so enables fall asynchronously with reset.
   assign active = (state == EXECUTE) && !bus.stall && reset;

   always_comb begin
      two_byte = 1'b0;
      taken    = 1'b0;
      alu_raw  = 2'b00;
      sel_raw  = 2'b00;
      acc_raw  = 1'b0;
      flg_raw  = 1'b0;
      rre_raw  = 1'b0;
      rwe_raw  = 1'b0;
      owe_raw  = 1'b0;
      case (instr_q)
         4'h0: begin two_byte = 1'b1; taken = c_q;  end  // JC
         4'h1: begin two_byte = 1'b1; taken = !c_q; end  // JNC
         4'h8: begin two_byte = 1'b1; taken = z_q;  end  // JZ
         4'h9: begin two_byte = 1'b1; taken = !z_q; end  // JNZ
         4'hC: begin two_byte = 1'b1; taken = 1'b1; end  // JMP
         4'h2: begin sel_raw = 2'b01; alu_raw = 2'b01; flg_raw = 1'b1; end  // CMPI
         4'h3: begin                                                        // CMPM
            two_byte = 1'b1; sel_raw = 2'b10; rre_raw = 1'b1;
            alu_raw = 2'b01; flg_raw = 1'b1;
         end
         4'h4: begin sel_raw = 2'b01; alu_raw = 2'b00; acc_raw = 1'b1; end  // LIT
         4'h5: begin sel_raw = 2'b11; alu_raw = 2'b00; acc_raw = 1'b1; end  // IN
         4'h6: begin                                                        // LD
            two_byte = 1'b1; sel_raw = 2'b10; rre_raw = 1'b1;
            alu_raw = 2'b00; acc_raw = 1'b1;
         end
         4'h7: begin two_byte = 1'b1; sel_raw = 2'b00; rwe_raw = 1'b1; end  // ST
         4'hA: begin                                                        // ADDI
            sel_raw = 2'b01; alu_raw = 2'b10; acc_raw = 1'b1; flg_raw = 1'b1;
         end
         4'hB: begin                                                        // ADDM
            two_byte = 1'b1; sel_raw = 2'b10; rre_raw = 1'b1;
            alu_raw = 2'b10; acc_raw = 1'b1; flg_raw = 1'b1;
         end
         4'hD: begin sel_raw = 2'b00; owe_raw = 1'b1; end                   // OUT
         4'hE: begin                                                        // NANDI
            sel_raw = 2'b01; alu_raw = 2'b11; acc_raw = 1'b1; flg_raw = 1'b1;
         end
         4'hF: begin                                                        // NANDM
            two_byte = 1'b1; sel_raw = 2'b10; rre_raw = 1'b1;
            alu_raw = 2'b11; acc_raw = 1'b1; flg_raw = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= FETCH;
         pc_q    <= PC_RESET;
         instr_q <= 4'h0;
         oprnd_q <= 4'h0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
      end else if (!bus.stall) begin
         case (state)
            FETCH: begin
               instr_q <= bus.program_byte[7:4];
               oprnd_q <= bus.program_byte[3:0];
               pc_q    <= pc_q + 1'b1;
               state   <= EXECUTE;
            end
            EXECUTE: begin
               state <= FETCH;
               if (flg_raw) begin
                  c_q <= bus.alu_c;
                  z_q <= bus.alu_z;
               end
               // The second byte of a 2-byte opcode is on program_byte right now.
               if (taken)
                  pc_q <= PC_W'({oprnd_q, bus.program_byte});
               else if (two_byte)
                  pc_q <= pc_q + 1'b1;
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign bus.PC          = pc_q;
   assign bus.phase       = (state == EXECUTE);
   assign bus.instr       = instr_q;
   assign bus.oprnd       = oprnd_q;
   assign bus.address_RAM = {oprnd_q, bus.program_byte};
   assign bus.c_flag      = c_q;
   assign bus.z_flag      = z_q;
   assign bus.alu_op      = active ? alu_raw : 2'b00;
   assign bus.bus_sel     = active ? sel_raw : 2'b00;
   assign bus.acc_we      = active & acc_raw;
   assign bus.flags_we    = active & flg_raw;
   assign bus.ram_re      = active & rre_raw;
   assign bus.ram_we      = active & rwe_raw;
   assign bus.out_we      = active & owe_raw;

endmodule

// File: tb/tb_up_sequencer.sv
// Directed bench for up_sequencer: small program in a ROM array, checks after each edge.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises stall during an ST EXECUTE and an asynchronous reset mid-instruction.
module tb_up_sequencer;

   logic       clock;
   logic       reset;
   logic [7:0] rom [0:4095];
   int         checks;
   int         errors;

   up_sequencer_if #(.PC_W(12)) sif();

   up_sequencer #(.PC_W(12), .PC_RESET(12'h000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (sif.master)
   );

   assign sif.program_byte = rom[sif.PC];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      sif.stall = 1'b0;
      sif.alu_c = 1'b0;
      sif.alu_z = 1'b0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      rom[12'h000] = 8'h44;  // LIT 4
      rom[12'h001] = 8'hA7;  // ADDI 7
      rom[12'h002] = 8'h2B;  // CMPI B
      rom[12'h003] = 8'hA1;  // ADDI 1 (clears Z)
      rom[12'h004] = 8'h83;  // JZ 321 (not taken)
      rom[12'h005] = 8'h21;
      rom[12'h006] = 8'hD0;  // OUT
      rom[12'h007] = 8'h50;  // IN
      rom[12'h008] = 8'h20;  // CMPI 0 (sets Z)
      rom[12'h009] = 8'hCA;  // JMP A01
      rom[12'h00A] = 8'h01;
      rom[12'hA01] = 8'h83;  // JZ 321 (taken)
      rom[12'hA02] = 8'h21;
      rom[12'h321] = 8'h75;  // ST 55A
      rom[12'h322] = 8'h5A;
      rom[12'h323] = 8'hCF;  // JMP FFF
      rom[12'h324] = 8'hFF;
      rom[12'hFFF] = 8'h4E;  // LIT E, PC wraps to 000

      // Reset state
      #12;
      chk("rst_pc", sif.PC, 12'h000);
      chk("rst_phase", 12'(sif.phase), 12'h0);
      chk("rst_instr", 12'(sif.instr), 12'h0);
      chk("rst_oprnd", 12'(sif.oprnd), 12'h0);
      chk("rst_c", 12'(sif.c_flag), 12'h0);
      chk("rst_z", 12'(sif.z_flag), 12'h0);
      chk("rst_acc_we", 12'(sif.acc_we), 12'h0);
      reset = 1'b1;

      // LIT 4
      tick();
      chk("lit_phase", 12'(sif.phase), 12'h1);
      chk("lit_instr", 12'(sif.instr), 12'h4);
      chk("lit_oprnd", 12'(sif.oprnd), 12'h4);
      chk("lit_pc", sif.PC, 12'h001);
      chk("lit_acc_we", 12'(sif.acc_we), 12'h1);
      chk("lit_bus_sel", 12'(sif.bus_sel), 12'h1);
      chk("lit_alu_op", 12'(sif.alu_op), 12'h0);
      chk("lit_flags_we", 12'(sif.flags_we), 12'h0);
      sif.alu_c = 1'b1;
      sif.alu_z = 1'b1;
      tick();
      chk("lit2_phase", 12'(sif.phase), 12'h0);
      chk("lit2_pc", sif.PC, 12'h001);
      chk("lit2_c", 12'(sif.c_flag), 12'h0);
      chk("lit2_z", 12'(sif.z_flag), 12'h0);
      chk("fetch_acc_we", 12'(sif.acc_we), 12'h0);
      chk("fetch_bus_sel", 12'(sif.bus_sel), 12'h0);

      // ADDI 7
      tick();
      sif.alu_c = 1'b1;
      sif.alu_z = 1'b0;
      #1;
      chk("addi_acc_we", 12'(sif.acc_we), 12'h1);
      chk("addi_flags_we", 12'(sif.flags_we), 12'h1);
      chk("addi_alu_op", 12'(sif.alu_op), 12'h2);
      chk("addi_bus_sel", 12'(sif.bus_sel), 12'h1);
      tick();
      chk("addi_c", 12'(sif.c_flag), 12'h1);
      chk("addi_z", 12'(sif.z_flag), 12'h0);
      chk("addi_pc", sif.PC, 12'h002);

      // CMPI B
      tick();
      sif.alu_c = 1'b0;
      sif.alu_z = 1'b1;
      #1;
      chk("cmpi_acc_we", 12'(sif.acc_we), 12'h0);
      chk("cmpi_flags_we", 12'(sif.flags_we), 12'h1);
      chk("cmpi_alu_op", 12'(sif.alu_op), 12'h1);
      tick();
      chk("cmpi_c", 12'(sif.c_flag), 12'h0);
      chk("cmpi_z", 12'(sif.z_flag), 12'h1);
      chk("cmpi_pc", sif.PC, 12'h003);

      // ADDI 1 -> clear both flags
      tick();
      sif.alu_c = 1'b0;
      sif.alu_z = 1'b0;
      tick();
      chk("addi1_z", 12'(sif.z_flag), 12'h0);

      // JZ not taken (z=0); alu_z=1 must not leak into the flags
      tick();
      sif.alu_z = 1'b1;
      #1;
      chk("jz0_pc_exec", sif.PC, 12'h005);
      chk("jz0_addr", sif.address_RAM, 12'h321);
      chk("jz0_flags_we", 12'(sif.flags_we), 12'h0);
      chk("jz0_acc_we", 12'(sif.acc_we), 12'h0);
      tick();
      chk("jz0_pc", sif.PC, 12'h006);
      chk("jz0_z", 12'(sif.z_flag), 12'h0);

      // OUT
      tick();
      chk("out_out_we", 12'(sif.out_we), 12'h1);
      chk("out_bus_sel", 12'(sif.bus_sel), 12'h0);
      tick();
      chk("out_pc", sif.PC, 12'h007);

      // IN
      tick();
      chk("in_bus_sel", 12'(sif.bus_sel), 12'h3);
      chk("in_acc_we", 12'(sif.acc_we), 12'h1);
      tick();

      // CMPI 0 -> z=1
      tick();
      sif.alu_c = 1'b0;
      sif.alu_z = 1'b1;
      tick();
      chk("cmpi0_z", 12'(sif.z_flag), 12'h1);
      chk("cmpi0_pc", sif.PC, 12'h009);

      // JMP A01
      tick();
      chk("jmp_pc_exec", sif.PC, 12'h00A);
      chk("jmp_addr", sif.address_RAM, 12'hA01);
      tick();
      chk("jmp_pc", sif.PC, 12'hA01);

      // JZ taken (z=1)
      tick();
      tick();
      chk("jz1_pc", sif.PC, 12'h321);

      // ST with stall held 3 clocks in EXECUTE
      tick();
      chk("st_ram_we", 12'(sif.ram_we), 12'h1);
      chk("st_addr", sif.address_RAM, 12'h55A);
      sif.stall = 1'b1;
      #1;
      chk("stall_ram_we0", 12'(sif.ram_we), 12'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_pc", sif.PC, 12'h322);
         chk("stall_phase", 12'(sif.phase), 12'h1);
         chk("stall_ram_we", 12'(sif.ram_we), 12'h0);
      end
      sif.stall = 1'b0;
      #1;
      chk("unstall_ram_we", 12'(sif.ram_we), 12'h1);
      tick();
      chk("st_done_ram_we", 12'(sif.ram_we), 12'h0);
      chk("st_done_pc", sif.PC, 12'h323);
      chk("st_done_phase", 12'(sif.phase), 12'h0);

      // JMP FFF, then PC wraps FFF -> 000
      tick();
      chk("jmpf_addr", sif.address_RAM, 12'hFFF);
      tick();
      chk("jmpf_pc", sif.PC, 12'hFFF);
      tick();
      chk("wrap_pc", sif.PC, 12'h000);
      chk("wrap_instr", 12'(sif.instr), 12'h4);
      tick();

      // LIT 4 again, async reset mid-EXECUTE
      tick();
      chk("pre_rst_acc_we", 12'(sif.acc_we), 12'h1);
      chk("pre_rst_pc", sif.PC, 12'h001);
      reset = 1'b0;
      #1;
      chk("midrst_pc", sif.PC, 12'h000);
      chk("midrst_phase", 12'(sif.phase), 12'h0);
      chk("midrst_acc_we", 12'(sif.acc_we), 12'h0);
      chk("midrst_bus_sel", 12'(sif.bus_sel), 12'h0);
      chk("midrst_instr", 12'(sif.instr), 12'h0);
      chk("midrst_z", 12'(sif.z_flag), 12'h0);
      reset = 1'b1;
      tick();
      chk("rec_pc", sif.PC, 12'h001);
      chk("rec_phase", 12'(sif.phase), 12'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
